// File: rtl/regfile_pkg.sv
// Shared register-file types: width constants, address/data typedefs,
// write payload struct and the round-robin pointer encoding.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One register-file write: destination plus payload
  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

  // Round-robin pointer; the encoding doubles as the last_grant value
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } ptr_state_t;

endpackage : regfile_pkg

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant.
// Ports:
//   i_valid      - request valids, bit i = requester i
//   i_hold       - suppress all grants this cycle
//   i_last_grant - requester most recently granted
//   o_grant_c    - one-hot (or zero) grant vector
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_hold,
  input  logic       i_last_grant,
  output logic [1:0] o_grant_c
);

  // On contention the requester that did not win last time goes first
  always_comb begin
    o_grant_c = 2'b00;
    if (!i_hold) begin
      unique case (i_valid)
        2'b01:   o_grant_c = 2'b01;
        2'b10:   o_grant_c = 2'b10;
        2'b11:   o_grant_c = i_last_grant ? 2'b01 : 2'b10;
        default: o_grant_c = 2'b00;
      endcase
    end
  end

endmodule : rr_arb2

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two valid/ready requesters
// with round-robin arbitration and a one-cycle registered write strobe.
// Ports:
//   clk, rst                 - clock, async active-low reset
//   hold                     - blocks all acceptance while high
//   reqN_valid/addr/data     - requester N write request
//   reqN_ready               - requester N accepted this cycle (combinational)
//   wr_en/wr_addr/wr_data    - registered register-file write port
//   last_grant               - round-robin pointer (last accepted requester)
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant
);

  ptr_state_t r_state;
  ptr_state_t w_state_next;
  logic [1:0] w_grant;
  logic       w_block;
  wr_req_t    w_sel;
  logic       r_wr_en;
  wr_req_t    r_wr;

  // Nothing is accepted while reset is asserted, so ready stays low too
  assign w_block = hold | ~rst;

  rr_arb2 u_rr_arb2 (
    .i_valid      ({req1_valid, req0_valid}),
    .i_hold       (w_block),
    .i_last_grant (r_state == LAST1),
    .o_grant_c    (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  // Pointer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LAST1;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointer next state: follows whichever requester was accepted
  always_comb begin
    w_state_next = r_state;
    if (w_grant[0]) begin
      w_state_next = LAST0;
    end else if (w_grant[1]) begin
      w_state_next = LAST1;
    end
  end

  // Winning payload
  always_comb begin
    w_sel = '{addr: req0_addr, data: req0_data};
    if (w_grant[1]) begin
      w_sel = '{addr: req1_addr, data: req1_data};
    end
  end

  // Registered write port; address/data hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en <= 1'b0;
      r_wr    <= '0;
    end else begin
      r_wr_en <= |w_grant;
      if (|w_grant) begin
        r_wr <= w_sel;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr.addr;
  assign wr_data    = r_wr.data;
  assign last_grant = (r_state == LAST1);

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected
// writes on acceptance, a negedge monitor pops and checks each strobe.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic              clk;
  logic              rst;
  logic              hold;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              last_grant;

  int n_checks;
  int n_fail;
  wr_req_t   exp_q[$];
  reg_data_t rf[32];

  regfile_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: one expected entry per acceptance at the previous edge
  always @(negedge clk) begin
    if (rst) begin
      chk("one_hot_ready", 32'(req0_ready & req1_ready), 32'd0);
      chk("wr_en", 32'(wr_en), 32'(exp_q.size() != 0));
      if (wr_en && exp_q.size() != 0) begin
        wr_req_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
        rf[wr_addr] = wr_data;
      end
    end
  end

  // One cycle: drive, check ready/pointer at negedge, record acceptance at posedge
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic h, input logic er0, input logic er1, input logic elg);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    hold = h;
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(er0));
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    chk("last_grant", 32'(last_grant), 32'(elg));
    @(posedge clk);
    if (er0) exp_q.push_back('{addr: a0, data: d0});
    if (er1) exp_q.push_back('{addr: a1, data: d1});
    #1;
  endtask

  task automatic idle(input logic elg);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, elg);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    foreach (rf[i]) rf[i] = '0;
    rst = 1'b1; hold = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    #2 rst = 1'b0;

    // Reset state with both requesters valid
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // First write after reset
    step(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 1, 0, 1);

    // req1 streaming to register 0, data 0..4
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'd0, 0, 0, 1, 0);
    for (int i = 1; i < 5; i++)
      step(0, 5'd0, 32'd0, 1, 5'd0, 32'(i), 0, 0, 1, 1);

    // Contention: order 0,1,0,1
    step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0, 1);
    step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 1, 0);
    step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0, 1);
    step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 1, 0);

    // Hold for 3 cycles, then release: req0 (1 - last_grant) first
    for (int i = 0; i < 3; i++)
      step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 0, 1);
    step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0, 1);

    // Same address from both requesters in grant order
    step(1, 5'd7, 32'hA, 0, 5'd0, 32'd0, 0, 1, 0, 0);
    step(0, 5'd0, 32'd0, 1, 5'd7, 32'hB, 0, 0, 1, 0);

    // Hold right after an acceptance keeps the pending strobe
    step(1, 5'd5, 32'h5, 0, 5'd0, 32'd0, 0, 1, 0, 1);
    step(1, 5'd6, 32'h6, 1, 5'd8, 32'h8, 1, 0, 0, 0);
    idle(0);
    chk("rf7_last_writer", rf[7], 32'hB);

    // Async reset mid-stream
    step(1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 0, 1, 0, 0);
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h1010;
    req1_valid = 1'b0; hold = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("mid_rst_last_grant", 32'(last_grant), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_rst_no_strobe", 32'(wr_en), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    step(1, 5'd12, 32'hC, 0, 5'd0, 32'd0, 0, 1, 0, 1);
    idle(0);
    idle(0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rf0_final", rf[0], 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_write_arbiter

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32 x 32-bit register file between two requesters, for example the ALU writeback and the load/memory writeback.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin.
- The winning address and data are registered and driven to the register file as a one-cycle write strobe.
- A downstream hold input can freeze all acceptance, for example during register-file test or flush.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address (32 registers)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous active-low reset; all state cleared while low
hold  input  1  when 1: no request is accepted this cycle
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
wr_en  output  1  register-file write enable, one cycle per accepted write
wr_addr  output  ADDR_W  register-file write address
wr_data  output  DATA_W  register-file write data
last_grant  output  1  requester most recently accepted (round-robin pointer)

Behaviour:
- Reset (rst low, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Any write accepted but not yet strobed is discarded.
- Accept: requester i's write is accepted in a cycle where reqi_valid=1 and reqi_ready=1.
- Hold rule: a requester holding valid=1 must keep addr and data stable until ready=1. Dropping valid before acceptance is legal and withdraws the request.
- Grant logic is combinational from the valid inputs, hold and last_grant:
  - hold=1: both ready=0.
  - Only req0_valid=1: req0_ready=1.
  - Only req1_valid=1: req1_ready=1.
  - Both valid: grant goes to requester (1 - last_grant).
  - No valid: both ready=0.
  - Exactly one or zero ready is high in any cycle, never both.
- Combinational valid-to-ready path is permitted. There is no path from ready to valid.
- State (pointer FSM, 2 states, encoded as last_grant):
  - LAST0 -> LAST1 on a req1 acceptance.
  - LAST1 -> LAST0 on a req0 acceptance.
  - Otherwise the state holds. hold=1 never changes the state.
- Write latency is 1 cycle. On the edge following an acceptance:
  - wr_en=1.
  - wr_addr and wr_data take the accepted requester's addr and data.
- If no acceptance occurs in a cycle, wr_en=0 the next cycle. wr_addr and wr_data hold their previous values; they are don't-care when wr_en=0.
- Throughput: one write per cycle. Back-to-back acceptances give a continuous wr_en=1 stream.
- Both requesters continuously valid: grants alternate 0,1,0,1. Neither requester waits more than 1 cycle beyond the other's grant.
- Same address from both requesters: no merging. Each accepted write is strobed in acceptance order, so the later one wins in the register file.
- Register address 0 gets no special treatment; it is written like any other register.
- hold asserted on the cycle after an acceptance does not cancel that pending strobe. hold only gates new acceptances.
- Reset asserted mid-stream: outputs clear immediately, without waiting for clk. After rst deasserts, the first accepted write strobes on the next edge.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - reg_addr_t and reg_data_t typedefs, reused by the register file and its datapath.
- Sub-module rr_arb2: combinational 2-way round-robin grant.
  - Inputs: the two valid inputs, hold, last_grant.
  - Outputs: two-bit one-hot grant.
- The top level holds the pointer flop and the registered write port.

Test Plan:
- Reset check: rst=0 with both requesters valid -> wr_en=0, both ready=0, last_grant=1. Release rst, req0 writes addr 3, data 0xDEADBEEF -> req0_ready=1 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=0xDEADBEEF.
- Contention: both requesters held valid for 4 cycles (req0 addr 1 data 0x11, req1 addr 2 data 0x22) -> accept order 0,1,0,1. wr_en=1 for 4 consecutive cycles with addresses 1,2,1,2. last_grant toggles each cycle.
- Hold: both requesters valid, hold=1 for 3 cycles -> no ready, wr_en=0, last_grant unchanged. Hold released -> requester (1 - last_grant) is accepted first.
- Single requester streaming: req1 valid for 5 cycles with data 0..4 -> req1_ready=1 every cycle. wr_en=1 for 5 cycles with wr_data 0,1,2,3,4. last_grant=1 throughout.
- Same address: req0 addr 7 data 0xA, then req1 addr 7 data 0xB in the next grant -> strobes for addr 7 occur in that order, so the register file holds 0xB.
- Async reset mid-stream: rst pulsed low between clock edges while wr_en=1 -> wr_en, wr_addr and wr_data are 0 before the next edge. The write accepted but not yet strobed never appears on wr_en.
